// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: selects the access address, splits it into
// bank/in-bank fields, and delays the access through a programmable delay line.
module dmem_access_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int CS_W       = 6,
  parameter int SUB_ADDR_W = 10,
  parameter int NUM_BANKS  = 40,
  parameter int MAX_DLY    = 3,
  parameter int DLY_W      = 2
) (
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic                  t_cs,
  input  logic [1:0]            mode,
  input  logic                  src_en_b,
  input  logic [ADDR_W-1:0]     src_addr,
  input  logic                  dst_en_b,
  input  logic                  dst_rw,
  input  logic [ADDR_W-1:0]     dst_addr,
  input  logic [ADDR_W-1:0]     ind_addr,
  input  logic                  ind_load,
  input  logic [DLY_W-1:0]      dly,
  input  logic                  err_clr,
  output logic                  dram_en_b,
  output logic                  dram_rw,
  output logic [CS_W-1:0]       dram_cs,
  output logic [SUB_ADDR_W-1:0] dram_addr,
  output logic                  busy,
  output logic                  err
);

  localparam logic [1:0] MODE_DIR_RD = 2'b00;
  localparam logic [1:0] MODE_DIR_WR = 2'b01;
  localparam logic [1:0] MODE_IND    = 2'b10;
  localparam logic [1:0] MODE_IND_PI = 2'b11;

  logic [ADDR_W-1:0]     ptr;
  logic [ADDR_W-1:0]     ptr_base;
  logic [ADDR_W-1:0]     ptr_nxt;

  logic                  req_valid;
  logic                  req_rw;
  logic [ADDR_W-1:0]     req_addr;
  logic [CS_W-1:0]       req_cs;
  logic [SUB_ADDR_W-1:0] req_sub;
  logic                  req_oor;
  logic                  req_cap;

  logic [MAX_DLY:0]      st_valid;
  logic [MAX_DLY:0]      st_rw;
  logic [CS_W-1:0]       st_cs  [0:MAX_DLY];
  logic [SUB_ADDR_W-1:0] st_sub [0:MAX_DLY];

  logic [DLY_W-1:0]      dly_sel;

  // ------------------------------------------------------------------
  // Request formation
  // ------------------------------------------------------------------
  always_comb begin
    req_valid = 1'b0;
    req_addr  = src_addr;
    req_rw    = 1'b1;
    unique case (mode)
      MODE_DIR_RD: begin
        req_valid = !src_en_b;
      end
      MODE_DIR_WR: begin
        req_valid = !dst_en_b;
        req_addr  = dst_addr;
        req_rw    = dst_rw;
      end
      MODE_IND: begin
        req_valid = !dst_en_b;
        req_addr  = ind_addr;
        req_rw    = dst_rw;
      end
      MODE_IND_PI: begin
        req_valid = !dst_en_b;
        req_addr  = ind_load ? ind_addr : ptr;
        req_rw    = dst_rw;
      end
      default: begin
        req_valid = 1'b0;
      end
    endcase
  end

  assign req_cs  = req_addr[ADDR_W-1 -: CS_W];
  assign req_sub = req_addr[SUB_ADDR_W-1:0];
  assign req_oor = req_valid && (32'(req_cs) >= NUM_BANKS);
  assign req_cap = req_valid && !req_oor;

  // ------------------------------------------------------------------
  // Auto-increment pointer; only the in-bank field advances and wraps
  // ------------------------------------------------------------------
  always_comb begin
    ptr_base = ind_load ? ind_addr : ptr;
    ptr_nxt  = ptr_base;
    if ((mode == MODE_IND_PI) && !dst_en_b) begin
      ptr_nxt[SUB_ADDR_W-1:0] = ptr_base[SUB_ADDR_W-1:0] + SUB_ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      ptr <= '0;
    end else if (t_cs) begin
      ptr <= ptr_nxt;
    end
  end

  // ------------------------------------------------------------------
  // Sticky out-of-range flag; a new violation beats a clear
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      err <= 1'b0;
    end else if (t_cs) begin
      if (req_oor) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

  // ------------------------------------------------------------------
  // Delay line. Stage 0 keeps its bank/address when an invalid entry is
  // captured, so every invalid entry carries the last valid bank/address
  // and the outputs hold them without a separate hold register.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      st_valid <= '0;
      st_rw    <= '1;
      for (int i = 0; i <= MAX_DLY; i++) begin
        st_cs[i]  <= '0;
        st_sub[i] <= '0;
      end
    end else if (t_cs) begin
      st_valid[0] <= req_cap;
      st_rw[0]    <= req_rw;
      if (req_cap) begin
        st_cs[0]  <= req_cs;
        st_sub[0] <= req_sub;
      end
      for (int i = 1; i <= MAX_DLY; i++) begin
        st_valid[i] <= st_valid[i-1];
        st_rw[i]    <= st_rw[i-1];
        st_cs[i]    <= st_cs[i-1];
        st_sub[i]   <= st_sub[i-1];
      end
    end
  end

  // ------------------------------------------------------------------
  // Output tap selection
  // ------------------------------------------------------------------
  always_comb begin
    dly_sel = dly;
    if (32'(dly) > MAX_DLY) begin
      dly_sel = DLY_W'(MAX_DLY);
    end
  end

  always_comb begin
    dram_en_b = 1'b1;
    dram_rw   = 1'b1;
    dram_cs   = '0;
    dram_addr = '0;
    busy      = 1'b0;
    for (int i = 0; i <= MAX_DLY; i++) begin
      if (i <= 32'(dly_sel)) begin
        busy = busy | st_valid[i];
      end
      if (i == 32'(dly_sel)) begin
        dram_en_b = !st_valid[i];
        dram_rw   = st_valid[i] ? st_rw[i] : 1'b1;
        dram_cs   = st_cs[i];
        dram_addr = st_sub[i];
      end
    end
  end

endmodule
